// File: rtl/err_burst_sched.sv
`default_nettype none
// ============================================================================
// Module   : err_burst_sched
// Purpose  : Periodic burst-error injector between a 2-bit channel encoder and
//            its decoder. Statistics counters exist only with ERR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module err_burst_sched #(
    parameter int CNT_W = 16,
    parameter int BL_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_offset,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [BL_W-1:0]  cfg_burst_len,
    input  logic [BL_W-1:0]  cfg_num_bursts,
    input  logic [1:0]       cfg_mask,
    input  logic             sym_valid,
    input  logic [1:0]       sym_in,
    output logic             sym_valid_o,
    output logic [1:0]       sym_out,
    output logic [1:0]       err_inj_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bad_bit_ct,
    output logic [CNT_W-1:0] word_ct
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OFFSET = 3'd1,
        BURST  = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_offset, r_period, r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [BL_W-1:0]  r_len, r_num, r_idx, w_idx_nxt, w_burst_base, w_len;
    logic [1:0]       r_mask, w_err_inj;
    logic [CNT_W-1:0] w_len_ext, w_gap_len;
    logic             w_accept, w_go_burst;

    assign w_accept  = start && !abort && (r_state == IDLE || r_state == DONE);
    assign w_len     = w_accept ? cfg_burst_len : r_len;
    assign w_len_ext = CNT_W'(r_len);
    assign w_gap_len = (r_period > w_len_ext) ? (r_period - w_len_ext) : '0;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_err_inj = (r_state == BURST && sym_valid && !abort) ? r_mask : 2'b00;

    assign busy = (r_state == OFFSET) || (r_state == BURST) || (r_state == GAP);
    assign done = (r_state == DONE);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_go_burst   = 1'b0;
        w_burst_base = r_idx;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        w_cnt_nxt    = '0;
                        w_idx_nxt    = '0;
                        w_burst_base = '0;
                        if (cfg_offset == '0) w_go_burst  = 1'b1;
                        else                  w_state_nxt = OFFSET;
                    end
                end
                OFFSET: begin
                    if (sym_valid) begin
                        if (w_cnt_inc == r_offset) begin
                            w_cnt_nxt  = '0;
                            w_go_burst = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                BURST: begin
                    if (sym_valid) begin
                        if (w_cnt_inc == w_len_ext) begin
                            w_cnt_nxt = '0;
                            w_idx_nxt = r_idx + 1'b1;
                            if (w_gap_len != '0) begin
                                w_state_nxt = GAP;
                            end else if (r_num != '0 && w_idx_nxt == r_num) begin
                                w_state_nxt = DONE;
                            end else begin
                                w_go_burst   = 1'b1;
                                w_burst_base = w_idx_nxt;
                            end
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                GAP: begin
                    // A zero-length gap only arises with zero-length bursts; it
                    // then consumes one symbol so the schedule keeps advancing.
                    if (sym_valid) begin
                        if (w_cnt_inc >= w_gap_len) begin
                            w_cnt_nxt = '0;
                            if (r_num != '0 && r_idx == r_num) w_state_nxt = DONE;
                            else                               w_go_burst  = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase

            // A zero-length burst completes instantly and goes straight to GAP.
            if (w_go_burst) begin
                if (w_len != '0) begin
                    w_state_nxt = BURST;
                    w_idx_nxt   = w_burst_base;
                end else begin
                    w_state_nxt = GAP;
                    w_idx_nxt   = w_burst_base + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_offset    <= '0;
            r_period    <= '0;
            r_len       <= '0;
            r_num       <= '0;
            r_mask      <= 2'b00;
            sym_valid_o <= 1'b0;
            sym_out     <= 2'b00;
            err_inj_o   <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            if (w_accept) begin
                r_offset <= cfg_offset;
                r_period <= cfg_period;
                r_len    <= cfg_burst_len;
                r_num    <= cfg_num_bursts;
                r_mask   <= cfg_mask;
            end
            sym_valid_o <= sym_valid;
            sym_out     <= sym_in ^ w_err_inj;
            err_inj_o   <= w_err_inj;
        end
    end

`ifdef ERR_STATS_EN
    logic [CNT_W-1:0] r_bad_bit_ct, r_word_ct;
    logic [1:0]       w_pop;
    logic [CNT_W:0]   w_bad_sum;

    assign w_pop     = {1'b0, w_err_inj[0]} + {1'b0, w_err_inj[1]};
    assign w_bad_sum = {1'b0, r_bad_bit_ct} + (CNT_W+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_bad_bit_ct <= '0;
            r_word_ct    <= '0;
        end else begin
            if (sym_valid && r_word_ct != '1) r_word_ct <= r_word_ct + 1'b1;
            r_bad_bit_ct <= w_bad_sum[CNT_W] ? '1 : w_bad_sum[CNT_W-1:0];
        end
    end

    assign bad_bit_ct = r_bad_bit_ct;
    assign word_ct    = r_word_ct;
`else
    assign bad_bit_ct = '0;
    assign word_ct    = '0;
`endif

endmodule
`default_nettype wire

// File: doc/err_burst_sched.md
ERR_BURST_SCHED -- requirements
Module: err_burst_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of period/offset/statistics counters.
REQ-002 SHALL have parameter BL_W, default 8, width of burst-length and burst-count fields.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; latches cfg_* and begins a schedule.
REQ-006 SHALL have port abort  input  1  returns FSM to IDLE next cycle.
REQ-007 SHALL have ports cfg_offset (CNT_W), cfg_period (CNT_W), cfg_burst_len (BL_W), cfg_num_bursts (BL_W), cfg_mask (2): inputs, sampled only on accepted start.
REQ-008 SHALL have port sym_valid  input  1  channel symbol strobe from encoder.
REQ-009 SHALL have port sym_in  input  2  encoder symbol {g1,g0}.
REQ-010 SHALL have ports sym_valid_o (1), sym_out (2), err_inj_o (2): outputs, registered symbol to decoder and flip mask applied.
REQ-011 SHALL have ports busy (1), done (1): outputs, status.
REQ-012 SHALL have ports bad_bit_ct (CNT_W), word_ct (CNT_W): outputs, statistics.

Function
REQ-013 SHALL implement FSM states IDLE, OFFSET, BURST, GAP, DONE.
REQ-014 SHALL register sym_out = sym_in XOR err_inj, sym_valid_o = sym_valid, with exactly 1-cycle latency in every state.
REQ-015 SHALL drive err_inj = cfg_mask only when state==BURST and sym_valid; otherwise 2'b00.
REQ-016 SHALL advance all schedule counters only on cycles with sym_valid=1.
REQ-017 SHALL in IDLE accept start, latch cfg_*, clear counters, enter OFFSET (or BURST if cfg_offset==0).
REQ-018 SHALL in OFFSET count cfg_offset valid symbols, then enter BURST.
REQ-019 SHALL in BURST corrupt cfg_burst_len consecutive valid symbols, then enter GAP, incrementing burst index.
REQ-020 SHALL in GAP pass cfg_period-cfg_burst_len valid symbols clean, then enter BURST, or DONE when burst index == cfg_num_bursts.
REQ-021 SHALL treat cfg_num_bursts==0 as unlimited (never reach DONE except via abort).
REQ-022 SHALL treat cfg_burst_len==0 as no injection: skip BURST, still honour period and burst count.
REQ-023 SHALL treat cfg_period<=cfg_burst_len as zero-length GAP (back-to-back bursts).
REQ-024 SHALL in DONE assert done=1 and hold until next accepted start or abort.
REQ-025 SHALL assert busy=1 in OFFSET, BURST, GAP; ignore start while busy.
REQ-026 SHALL give abort priority over start and over any transition in the same cycle; err_inj=0 from the abort cycle on.
REQ-027 SHALL increment word_ct per sym_valid and bad_bit_ct by popcount(err_inj) per cycle, both saturating at all-ones, cleared on accepted start.

Reset
REQ-028 SHALL on rst=1 force IDLE and clear sym_out, sym_valid_o, err_inj_o, busy, done, bad_bit_ct, word_ct and all internal counters to 0.
REQ-029 SHALL make reset mid-schedule discard the schedule; no symbol is corrupted in the cycle after reset deasserts.

Configuration
REQ-030 SHALL with ERR_STATS_EN defined include the bad_bit_ct and word_ct counters per REQ-027.
REQ-031 SHALL without ERR_STATS_EN tie bad_bit_ct and word_ct to 0 and synthesize no statistics counters; all other behaviour identical.

Verification
REQ-032 SHALL cover: offset=245, burst_len=11, period=11, num_bursts=1, mask=01, continuous valid -> symbols 245..255 have bit0 flipped, done at symbol 256, bad_bit_ct=11.
REQ-033 SHALL cover: offset=0, burst_len=2, period=8, num_bursts=3, mask=11 -> flips on symbols 0-1, 8-9, 16-17; bad_bit_ct=12; done after symbol 23.
REQ-034 SHALL cover: burst_len=4 with sym_valid toggled every other cycle -> exactly 4 valid symbols corrupted; invalid cycles have err_inj_o=0.
REQ-035 SHALL cover: abort asserted with start in the 3rd BURST symbol -> err_inj_o=0 next cycle, busy=0, FSM IDLE, start ignored.
REQ-036 SHALL cover: rst mid-GAP, then start with burst_len=0, num_bursts=2, period=5 -> no flips, done after symbol 9, bad_bit_ct=0.
REQ-037 SHALL cover: num_bursts=0, period=burst_len=1 -> every valid symbol corrupted indefinitely, done stays 0.
